load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FUNC3 access codes, FSM encoding
// and the legality check used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } lsu_state_e;

  // Undefined codes and unsigned stores are folded into the misaligned fault.
  function automatic logic access_ok(input logic [2:0] func3,
                                     input logic [1:0] addr_lo,
                                     input logic       is_store);
    logic ok;
    ok = 1'b0;
    case (func3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension from a 32-bit memory word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = i_rdata;
    case (i_func3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_data = {24'd0, w_shifted[7:0]};
      F3_HU:   o_data = {16'd0, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one aligned request, holds the strobe
// until memory drops busywait, then spends one DONE cycle before the next.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_wb_data,
  input  logic        i_mem_fwd_sel,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_busywait,
  output logic        o_dmem_read,
  output logic        o_dmem_write,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_byte_en,
  output logic [31:0] o_load_data,
  output logic        o_stall,
  output logic        o_misaligned
);

  lsu_state_e  r_state, w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_func3;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic [31:0] r_load_data;

  logic        w_req;
  logic        w_ok;
  logic        w_accept;
  logic        w_complete;
  logic [31:0] w_load_aligned;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_data;

  assign w_req      = i_mem_read | i_mem_write;
  // A simultaneous read is dropped, so legality follows the store rules.
  assign w_ok       = access_ok(i_func3, i_addr[1:0], i_mem_write);
  assign w_accept   = (r_state == S_IDLE) & w_req & w_ok;
  assign w_complete = (r_state == S_ACCESS) & ~i_dmem_busywait;

  lsu_load_align u_align (
    .i_rdata   (i_dmem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_func3   (r_func3),
    .o_data    (w_load_aligned)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_func3     <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= i_addr;
        r_func3    <= i_func3;
        r_wdata    <= i_mem_fwd_sel ? i_wb_data : i_rs2_data;
        r_is_write <= i_mem_write;
      end
      if (w_complete && !r_is_write)
        r_load_data <= w_load_aligned;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ACCESS;
      S_ACCESS: if (!i_dmem_busywait) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_store_be = 4'b1111;
    case (r_func3)
      F3_B:    w_store_be = 4'b0001 << r_addr[1:0];
      F3_H:    w_store_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_store_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_store_data = r_wdata;
    case (r_func3)
      F3_B:    w_store_data = {4{r_wdata[7:0]}};
      F3_H:    w_store_data = {2{r_wdata[15:0]}};
      default: w_store_data = r_wdata;
    endcase
  end

  // Everything combinational is masked by reset, including a live ACCESS.
  always_comb begin
    o_stall        = 1'b0;
    o_misaligned   = 1'b0;
    o_dmem_read    = 1'b0;
    o_dmem_write   = 1'b0;
    o_dmem_byte_en = 4'b0000;
    if (!i_reset) begin
      o_stall      = w_accept | (r_state == S_ACCESS);
      o_misaligned = (r_state == S_IDLE) & w_req & ~w_ok;
      if (r_state == S_ACCESS) begin
        o_dmem_read  = ~r_is_write;
        o_dmem_write = r_is_write;
        if (r_is_write) o_dmem_byte_en = w_store_be;
      end
    end
  end

  assign o_dmem_addr  = {r_addr[31:2], 2'b00};
  assign o_dmem_wdata = w_store_data;
  assign o_load_data  = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, fwd, busy;
  logic [2:0]  f3;
  logic [31:0] addr, rs2, wb, rdata;
  logic        dmem_read, dmem_write, stall, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  byte_en;

  load_store_unit dut (
    .i_clk(clk), .i_reset(rst), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_func3(f3), .i_addr(addr), .i_rs2_data(rs2), .i_wb_data(wb),
    .i_mem_fwd_sel(fwd), .i_dmem_rdata(rdata), .i_dmem_busywait(busy),
    .o_dmem_read(dmem_read), .o_dmem_write(dmem_write), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_byte_en(byte_en), .o_load_data(load_data),
    .o_stall(stall), .o_misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int size_of(input logic [2:0] f);
    return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit legal(input bit wr, input logic [2:0] f, input logic [31:0] a);
    bit known;
    known = wr ? (f inside {3'b000, 3'b001, 3'b010})
               : (f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    return known && ((a % size_of(f)) == 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [2:0] f);
    logic [31:0] v;
    v = d >> (8 * (a % 4));
    case (f)
      3'b000:  return 32'($signed(v[7:0]));
      3'b001:  return 32'($signed(v[15:0]));
      3'b100:  return v & 32'h0000_00FF;
      3'b101:  return v & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] f);
    if (size_of(f) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (size_of(f) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] f);
    if (size_of(f) == 1) return 4'(1 << (a % 4));
    if (size_of(f) == 2) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // ---------------- transaction model ----------------
  int          m_phase;   // 0 waiting for request, 1 memory access, 2 completion cycle
  bit          m_wr;
  logic [31:0] m_addr, m_data, m_ld;
  logic [2:0]  m_f3;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_ld <= '0; m_addr <= '0; m_data <= '0; m_f3 <= '0; m_wr <= 0;
    end else begin
      case (m_phase)
        0: if ((mem_read || mem_write) && legal(mem_write, f3, addr)) begin
             m_wr <= mem_write; m_addr <= addr; m_f3 <= f3;
             m_data <= fwd ? wb : rs2; m_phase <= 1;
           end
        1: if (!busy) begin
             if (!m_wr) m_ld <= exp_load(rdata, m_addr, m_f3);
             m_phase <= 2;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit req, lg, live;
      req  = mem_read || mem_write;
      lg   = legal(mem_write, f3, addr);
      live = !rst && m_phase == 1;
      chk("stall", stall, !rst && ((m_phase == 0 && req && lg) || m_phase == 1));
      chk("misaligned", misaligned, !rst && m_phase == 0 && req && !lg);
      chk("dmem_read", dmem_read, live && !m_wr);
      chk("dmem_write", dmem_write, live && m_wr);
      chk("byte_en", byte_en, (live && m_wr) ? exp_be(m_addr, m_f3) : 4'b0000);
      chk("load_data", load_data, m_ld);
      if (live) chk("dmem_addr", dmem_addr, m_addr & 32'hFFFF_FFFC);
      if (live && m_wr) chk("dmem_wdata", dmem_wdata, exp_wdata(m_data, m_f3));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] t_ld, t_addr, t_wdata;
  logic [3:0]  t_be;
  bit          t_strobe, t_wstrobe;

  // Request stays asserted while stalled; memory holds busywait for nbusy
  // cycles counted from the request cycle.
  task automatic do_req(input bit rd, input bit wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] w, input bit fs, input int nbusy,
                        input logic [31:0] rdat, output int nstall, output bit mis);
    bit done;
    mem_read = rd; mem_write = wr; f3 = f; addr = a; rs2 = d; wb = w; fwd = fs;
    rdata = rdat; busy = (nbusy > 0);
    nstall = 0; mis = 0; done = 0; t_strobe = 0; t_wstrobe = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (misaligned) mis = 1;
      if ((dmem_read || dmem_write) && !t_strobe) begin
        t_strobe = 1; t_wstrobe = dmem_write;
        t_addr = dmem_addr; t_wdata = dmem_wdata; t_be = byte_en;
      end
      if (!stall) begin t_ld = load_data; done = 1; end
      else nstall++;
      @(posedge clk); #1;
      busy = (n < nbusy);
      if (done) break;
    end
    chk("req_completes", done, 1);
    mem_read = 0; mem_write = 0; busy = 0;
  endtask

  int ns;
  bit mis;

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; fwd = 0; busy = 0;
    f3 = 0; addr = 0; rs2 = 0; wb = 0; rdata = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    mem_read = 1;  // request during reset must be ignored
    @(negedge clk);
    chk("reset_load_data", load_data, 32'h0);
    chk("reset_stall", stall, 0);
    @(posedge clk); #1 rst = 0; mem_read = 0;

    do_req(1, 0, 3'b010, 32'h100, 0, 0, 0, 3, 32'hDEADBEEF, ns, mis);
    chk("lw_stall_cycles", ns, 4);
    chk("lw_data", t_ld, 32'hDEADBEEF);

    do_req(1, 0, 3'b000, 32'h103, 0, 0, 0, 0, 32'h80FF_FF7F, ns, mis);
    chk("lb_stall_cycles", ns, 2);
    chk("lb_data", t_ld, 32'hFFFF_FF80);
    do_req(1, 0, 3'b100, 32'h103, 0, 0, 0, 0, 32'h80FF_FF7F, ns, mis);
    chk("lbu_data", t_ld, 32'h0000_0080);

    do_req(1, 0, 3'b001, 32'h102, 0, 0, 0, 1, 32'h8001_1234, ns, mis);
    chk("lh_data", t_ld, 32'hFFFF_8001);
    do_req(1, 0, 3'b101, 32'h100, 0, 0, 0, 0, 32'h8001_1234, ns, mis);
    chk("lhu_data", t_ld, 32'h0000_1234);

    do_req(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 0, 32'hFFFF_FFFF, ns, mis);
    chk("sh_wdata", t_wdata, 32'hABCDABCD);
    chk("sh_be", t_be, 4'b1100);
    chk("sh_addr", t_addr, 32'h200);
    chk("sh_keeps_load", t_ld, 32'h0000_1234);

    do_req(0, 1, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1, 2, 0, ns, mis);
    chk("sw_fwd_wdata", t_wdata, 32'hCAFEF00D);
    chk("sw_be", t_be, 4'b1111);

    do_req(0, 1, 3'b000, 32'h105, 32'h0000_9955, 0, 0, 0, 0, ns, mis);
    chk("sb_wdata", t_wdata, 32'h5555_5555);
    chk("sb_be", t_be, 4'b0010);
    chk("sb_addr", t_addr, 32'h104);

    do_req(1, 1, 3'b010, 32'h010, 32'h1122_3344, 0, 0, 0, 32'h7777_7777, ns, mis);
    chk("rw_is_write", t_wstrobe, 1);
    chk("rw_keeps_load", t_ld, 32'h0000_1234);

    do_req(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 32'h5555_5555, ns, mis);
    chk("mis_lw_pulse", mis, 1);
    chk("mis_lw_stall", ns, 0);
    chk("mis_lw_strobe", t_strobe, 0);

    do_req(0, 1, 3'b100, 32'h100, 32'h1, 0, 0, 0, 0, ns, mis);
    chk("store_bu_fault", mis, 1);
    chk("store_bu_strobe", t_strobe, 0);

    // reset during the second ACCESS cycle of a load
    mem_read = 1; f3 = 3'b010; addr = 32'h400; busy = 1; rdata = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_read", dmem_read, 0);
    @(posedge clk); #1 rst = 0; mem_read = 0; busy = 0;
    @(negedge clk);
    chk("rst_after_stall", stall, 0);
    chk("rst_after_load", load_data, 32'h0);
    chk("rst_after_read", dmem_read, 0);

    do_req(1, 0, 3'b010, 32'h008, 0, 0, 0, 2, 32'h0BADF00D, ns, mis);
    chk("post_rst_stall_cycles", ns, 3);
    chk("post_rst_data", t_ld, 32'h0BADF00D);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
